// File: rtl/issue_ctrl.sv
// issue_ctrl
// Sequencer between the decode stage and the execution resources. It takes
// one decoded instruction per handshake and reads operand A, then operand B,
// through a single shared register-file read port. A 32-entry write
// scoreboard holds back a read whose source still has a write in flight.
// When the operands are ready, the instruction is dispatched to the selected
// units over a valid/ready handshake.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   flush_i               drop the held instruction, return to IDLE
//   dec_valid_i/_ready_o  decode handshake
//   req_rf_ra_i/_rb_i     operand A/B needed
//   rf_raddr_a_i/_b_i     source registers
//   rf_we_i, rf_waddr_i   instruction writes rd / rd index
//   req_alu_i, req_data_i, req_pc_alu_i  unit requests
//   rf_re_o, rf_raddr_o   shared read port strobe and address
//   rf_rdata_i            read data (combinational, same cycle)
//   op_a_o, op_b_o        captured operands
//   waddr_o               latched rd
//   exec_valid_o/_ready_i dispatch handshake
//   exec_unit_o           {pc_alu, lsu, alu}
//   wb_valid_i/wb_waddr_i register-file write-back (clears busy bits)
//   hazard_o              stalled on a scoreboard hit this cycle
//   stall_cnt_o           saturating count of hazard cycles

module issue_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        dec_valid_i,
  output logic        dec_ready_o,
  input  logic        req_rf_ra_i,
  input  logic        req_rf_rb_i,
  input  logic [4:0]  rf_raddr_a_i,
  input  logic [4:0]  rf_raddr_b_i,
  input  logic        rf_we_i,
  input  logic [4:0]  rf_waddr_i,
  input  logic        req_alu_i,
  input  logic        req_data_i,
  input  logic        req_pc_alu_i,
  output logic        rf_re_o,
  output logic [4:0]  rf_raddr_o,
  input  logic [31:0] rf_rdata_i,
  output logic [31:0] op_a_o,
  output logic [31:0] op_b_o,
  output logic [4:0]  waddr_o,
  output logic        exec_valid_o,
  output logic [2:0]  exec_unit_o,
  input  logic        exec_ready_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_waddr_i,
  output logic        hazard_o,
  output logic [15:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    ISSUE  = 2'd3
  } state_t;

  state_t      state;
  logic        need_b;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic        rf_we;
  logic [31:0] busy;
  logic [31:0] busy_set;
  logic [31:0] busy_clr;
  logic [31:0] busy_nxt;
  logic        src_busy;
  logic        dispatch;
  logic [2:0]  dec_units;

  assign dec_units = {req_pc_alu_i, req_data_i, req_alu_i};

  // The scoreboard is consulted with the registered mask, so a bit that is
  // being cleared by a write-back this cycle still stalls the read. There is
  // no bypass; the value is read from the register file one cycle later.
  always_comb begin
    src_busy = 1'b0;
    if (state == READ_A)
      src_busy = busy[raddr_a];
    else if (state == READ_B)
      src_busy = busy[raddr_b];
  end

  // Handshake outputs are gated by reset. Dispatch is also gated by flush,
  // so a flushed instruction can never be accepted downstream.
  assign rf_raddr_o   = (state == READ_B) ? raddr_b : raddr_a;
  assign hazard_o     = !rst_i && src_busy;
  assign rf_re_o      = !rst_i && ((state == READ_A) || (state == READ_B)) && !src_busy;
  assign dec_ready_o  = !rst_i && (state == IDLE);
  assign exec_valid_o = !rst_i && (state == ISSUE) && !flush_i;
  assign dispatch     = exec_valid_o && exec_ready_i;

  // A set at dispatch takes priority over a clear from write-back at the same
  // index. Register x0 never has a pending write.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (wb_valid_i)
      busy_clr[wb_waddr_i] = 1'b1;
    if (dispatch && rf_we && (waddr_o != 5'd0))
      busy_set[waddr_o] = 1'b1;
    busy_nxt    = (busy & ~busy_clr) | busy_set;
    busy_nxt[0] = 1'b0;
  end

  // Main sequencer. Flush returns to IDLE and discards the held instruction,
  // but the busy mask keeps tracking writes that were already dispatched.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= IDLE;
      busy        <= '0;
      need_b      <= 1'b0;
      raddr_a     <= '0;
      raddr_b     <= '0;
      rf_we       <= 1'b0;
      op_a_o      <= '0;
      op_b_o      <= '0;
      waddr_o     <= '0;
      exec_unit_o <= '0;
      stall_cnt_o <= '0;
    end else begin
      busy <= busy_nxt;
      if (hazard_o && (stall_cnt_o != 16'hFFFF))
        stall_cnt_o <= stall_cnt_o + 16'd1;

      if (flush_i) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // An instruction that requests no unit is a NOP and is dropped.
            if (dec_valid_i && (dec_units != 3'b000)) begin
              need_b      <= req_rf_rb_i;
              raddr_a     <= rf_raddr_a_i;
              raddr_b     <= rf_raddr_b_i;
              rf_we       <= rf_we_i;
              waddr_o     <= rf_waddr_i;
              exec_unit_o <= dec_units;
              op_a_o      <= '0;
              op_b_o      <= '0;
              if (req_rf_ra_i)
                state <= READ_A;
              else if (req_rf_rb_i)
                state <= READ_B;
              else
                state <= ISSUE;
            end
          end
          READ_A: begin
            if (!src_busy) begin
              op_a_o <= rf_rdata_i;
              state  <= need_b ? READ_B : ISSUE;
            end
          end
          READ_B: begin
            if (!src_busy) begin
              op_b_o <= rf_rdata_i;
              state  <= ISSUE;
            end
          end
          ISSUE: begin
            if (exec_ready_i)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// tb_issue_ctrl
// Directed bench for issue_ctrl. The main process drives instructions and
// checks per-cycle control outputs. Every instruction that should reach
// dispatch pushes its expected operands/units/rd into a queue. A separate
// monitor pops that queue on each dispatch handshake and compares.

module tb_issue_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        dec_valid_i;
  logic        dec_ready_o;
  logic        req_rf_ra_i;
  logic        req_rf_rb_i;
  logic [4:0]  rf_raddr_a_i;
  logic [4:0]  rf_raddr_b_i;
  logic        rf_we_i;
  logic [4:0]  rf_waddr_i;
  logic        req_alu_i;
  logic        req_data_i;
  logic        req_pc_alu_i;
  logic        rf_re_o;
  logic [4:0]  rf_raddr_o;
  logic [31:0] rf_rdata_i;
  logic [31:0] op_a_o;
  logic [31:0] op_b_o;
  logic [4:0]  waddr_o;
  logic        exec_valid_o;
  logic [2:0]  exec_unit_o;
  logic        exec_ready_i;
  logic        wb_valid_i;
  logic [4:0]  wb_waddr_i;
  logic        hazard_o;
  logic [15:0] stall_cnt_o;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  unit;
    logic [4:0]  waddr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] regs[32];
  int          tests_run = 0;
  int          tests_failed = 0;

  issue_ctrl dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .req_rf_ra_i(req_rf_ra_i), .req_rf_rb_i(req_rf_rb_i),
    .rf_raddr_a_i(rf_raddr_a_i), .rf_raddr_b_i(rf_raddr_b_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i),
    .req_alu_i(req_alu_i), .req_data_i(req_data_i), .req_pc_alu_i(req_pc_alu_i),
    .rf_re_o(rf_re_o), .rf_raddr_o(rf_raddr_o), .rf_rdata_i(rf_rdata_i),
    .op_a_o(op_a_o), .op_b_o(op_b_o), .waddr_o(waddr_o),
    .exec_valid_o(exec_valid_o), .exec_unit_o(exec_unit_o),
    .exec_ready_i(exec_ready_i),
    .wb_valid_i(wb_valid_i), .wb_waddr_i(wb_waddr_i),
    .hazard_o(hazard_o), .stall_cnt_o(stall_cnt_o)
  );

  // 10 ns clock
  always #5 clk_i = ~clk_i;

  // Register-file model behind the shared combinational read port
  assign rf_rdata_i = regs[rf_raddr_o];

  // Single comparison point; every check steps the same counters
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance to 1 ns after the next rising edge
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Present one instruction in the current (IDLE) cycle and confirm it is
  // accepted; returns 1 ns into the following cycle with dec_valid low
  task automatic applyStimulus(input logic ra_en, input logic [4:0] ra,
                               input logic rb_en, input logic [4:0] rb,
                               input logic we, input logic [4:0] rd,
                               input logic [2:0] units);
    req_rf_ra_i  = ra_en;
    rf_raddr_a_i = ra;
    req_rf_rb_i  = rb_en;
    rf_raddr_b_i = rb;
    rf_we_i      = we;
    rf_waddr_i   = rd;
    {req_pc_alu_i, req_data_i, req_alu_i} = units;
    dec_valid_i  = 1'b1;
    #3;
    checkOutput("accept_ready", dec_ready_o, 1);
    step();
    dec_valid_i = 1'b0;
  endtask

  task automatic pushExp(input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] unit, input logic [4:0] rd);
    exp_t e;
    e.a = a; e.b = b; e.unit = unit; e.waddr = rd;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every dispatch handshake against the scoreboard queue
  always @(negedge clk_i) begin
    if (!rst_i && exec_valid_o && exec_ready_i) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("[TB] FAIL unexpected_dispatch: got unit 0x%0h rd %0d, expected no dispatch",
                 exec_unit_o, waddr_o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("dispatch_op_a", op_a_o, e.a);
        checkOutput("dispatch_op_b", op_b_o, e.b);
        checkOutput("dispatch_unit", {29'd0, exec_unit_o}, {29'd0, e.unit});
        checkOutput("dispatch_waddr", {27'd0, waddr_o}, {27'd0, e.waddr});
      end
    end
  end

  // Directed sequence; every cycle body is drive, wait 3 ns, check, step
  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 32'hDEAD_0000 | i;
    regs[0]  = 32'h0;
    regs[5]  = 32'h11;
    regs[6]  = 32'h22;
    regs[7]  = 32'h77;
    regs[9]  = 32'h99;
    regs[10] = 32'hAA;
    regs[11] = 32'hB1;
    regs[12] = 32'hC2;

    rst_i = 1'b1; flush_i = 1'b0; dec_valid_i = 1'b0;
    req_rf_ra_i = 1'b0; req_rf_rb_i = 1'b0;
    rf_raddr_a_i = '0; rf_raddr_b_i = '0; rf_we_i = 1'b0; rf_waddr_i = '0;
    req_alu_i = 1'b0; req_data_i = 1'b0; req_pc_alu_i = 1'b0;
    exec_ready_i = 1'b1; wb_valid_i = 1'b0; wb_waddr_i = '0;

    // Reset state
    step(); step();
    #3;
    checkOutput("rst_dec_ready", dec_ready_o, 0);
    checkOutput("rst_exec_valid", exec_valid_o, 0);
    checkOutput("rst_rf_re", rf_re_o, 0);
    step();
    rst_i = 1'b0;
    #3;
    checkOutput("post_rst_dec_ready", dec_ready_o, 1);
    checkOutput("post_rst_stall_cnt", stall_cnt_o, 0);
    checkOutput("post_rst_op_a", op_a_o, 0);
    checkOutput("post_rst_unit", exec_unit_o, 0);
    step();

    // Two-operand ALU instruction: reads x5 then x6, dispatches in cycle 3
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd7, 3'b001);
    pushExp(32'h11, 32'h22, 3'b001, 5'd7);
    #3;
    checkOutput("t1_c1_rf_re", rf_re_o, 1);
    checkOutput("t1_c1_raddr", rf_raddr_o, 5);
    checkOutput("t1_c1_dec_ready", dec_ready_o, 0);
    step(); #3;
    checkOutput("t1_c2_rf_re", rf_re_o, 1);
    checkOutput("t1_c2_raddr", rf_raddr_o, 6);
    step(); #3;
    checkOutput("t1_c3_exec_valid", exec_valid_o, 1);
    step();

    // Read of x7 while busy: four hazard cycles, write-back in the fourth
    applyStimulus(1'b1, 5'd7, 1'b0, 5'd0, 1'b0, 5'd8, 3'b010);
    pushExp(32'h77, 32'h0, 3'b010, 5'd8);
    for (int k = 1; k <= 4; k++) begin
      if (k == 4) begin wb_valid_i = 1'b1; wb_waddr_i = 5'd7; end
      #3;
      checkOutput("t2_hazard", hazard_o, 1);
      checkOutput("t2_rf_re_stalled", rf_re_o, 0);
      step();
      wb_valid_i = 1'b0;
    end
    #3;
    checkOutput("t2_hazard_clear", hazard_o, 0);
    checkOutput("t2_rf_re", rf_re_o, 1);
    checkOutput("t2_raddr", rf_raddr_o, 7);
    step(); #3;
    checkOutput("t2_exec_valid", exec_valid_o, 1);
    checkOutput("t2_stall_cnt", stall_cnt_o, 4);
    step();

    // rd=0 write never marks x0 busy; following read of x0 does not stall
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 3'b100);
    pushExp(32'h0, 32'h0, 3'b100, 5'd0);
    #3;
    checkOutput("t3_exec_valid", exec_valid_o, 1);
    step();
    applyStimulus(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 3'b001);
    pushExp(32'h0, 32'h0, 3'b001, 5'd1);
    #3;
    checkOutput("t3_x0_hazard", hazard_o, 0);
    checkOutput("t3_x0_rf_re", rf_re_o, 1);
    step(); #3;
    checkOutput("t3_x0_exec_valid", exec_valid_o, 1);
    step();

    // Back-pressure: ISSUE held 5 cycles, outputs stable
    applyStimulus(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd3, 3'b011);
    pushExp(32'h11, 32'h0, 3'b011, 5'd3);
    exec_ready_i = 1'b0;
    #3;
    checkOutput("t4_rf_re", rf_re_o, 1);
    step();
    for (int k = 0; k < 5; k++) begin
      #3;
      checkOutput("t4_hold_valid", exec_valid_o, 1);
      checkOutput("t4_hold_op_a", op_a_o, 32'h11);
      checkOutput("t4_hold_op_b", op_b_o, 0);
      checkOutput("t4_hold_unit", exec_unit_o, 3);
      checkOutput("t4_hold_dec_ready", dec_ready_o, 0);
      step();
    end
    exec_ready_i = 1'b1;
    #3;
    checkOutput("t4_release_valid", exec_valid_o, 1);
    step();

    // Flush: mark x10 busy first, then flush in READ_B and in ISSUE
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd10, 3'b001);
    pushExp(32'h0, 32'h0, 3'b001, 5'd10);
    #3;
    checkOutput("t5_busy10_valid", exec_valid_o, 1);
    step();
    applyStimulus(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd11, 3'b001);
    #3;
    checkOutput("t5_fa_rf_re", rf_re_o, 1);
    step();
    flush_i = 1'b1;
    #3;
    checkOutput("t5_fb_exec_valid", exec_valid_o, 0);
    step();
    flush_i = 1'b0;
    #3;
    checkOutput("t5_fb_idle", dec_ready_o, 1);
    checkOutput("t5_fb_no_valid", exec_valid_o, 0);
    step();
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd12, 3'b010);
    flush_i = 1'b1;
    #3;
    checkOutput("t5_fi_exec_valid", exec_valid_o, 0);
    step();
    flush_i = 1'b0;
    #3;
    checkOutput("t5_fi_idle", dec_ready_o, 1);
    checkOutput("t5_fi_no_valid", exec_valid_o, 0);
    step();
    // Flush in IDLE with dec_valid drops the instruction
    req_alu_i = 1'b1; dec_valid_i = 1'b1; flush_i = 1'b1;
    #3;
    step();
    dec_valid_i = 1'b0; flush_i = 1'b0;
    #3;
    checkOutput("t5_fidle_ready", dec_ready_o, 1);
    checkOutput("t5_fidle_no_valid", exec_valid_o, 0);
    step();
    // x11/x12 were never marked busy
    applyStimulus(1'b1, 5'd11, 1'b1, 5'd12, 1'b0, 5'd13, 3'b001);
    pushExp(32'hB1, 32'hC2, 3'b001, 5'd13);
    #3;
    checkOutput("t5_x11_hazard", hazard_o, 0);
    checkOutput("t5_x11_rf_re", rf_re_o, 1);
    step(); #3;
    checkOutput("t5_x12_hazard", hazard_o, 0);
    checkOutput("t5_x12_rf_re", rf_re_o, 1);
    step(); #3;
    checkOutput("t5_x1112_valid", exec_valid_o, 1);
    step();
    // x10 still busy; clearing write-back this cycle still stalls
    applyStimulus(1'b1, 5'd10, 1'b0, 5'd0, 1'b0, 5'd14, 3'b100);
    pushExp(32'hAA, 32'h0, 3'b100, 5'd14);
    wb_valid_i = 1'b1; wb_waddr_i = 5'd10;
    #3;
    checkOutput("t5_x10_hazard", hazard_o, 1);
    step();
    wb_valid_i = 1'b0;
    #3;
    checkOutput("t5_x10_hazard_clear", hazard_o, 0);
    checkOutput("t5_x10_raddr", rf_raddr_o, 10);
    step(); #3;
    checkOutput("t5_x10_valid", exec_valid_o, 1);
    checkOutput("t5_stall_cnt", stall_cnt_o, 5);
    step();

    // Set wins over same-cycle clear at x9, then reset mid READ_A
    applyStimulus(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 3'b001);
    pushExp(32'h0, 32'h0, 3'b001, 5'd9);
    wb_valid_i = 1'b1; wb_waddr_i = 5'd9;
    #3;
    checkOutput("t6_valid", exec_valid_o, 1);
    step();
    wb_valid_i = 1'b0;
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd15, 3'b001);
    #3;
    checkOutput("t6_set_wins_hazard", hazard_o, 1);
    checkOutput("t6_set_wins_rf_re", rf_re_o, 0);
    step();
    rst_i = 1'b1;
    #3;
    checkOutput("t6_rst_dec_ready", dec_ready_o, 0);
    checkOutput("t6_rst_hazard", hazard_o, 0);
    checkOutput("t6_rst_rf_re", rf_re_o, 0);
    checkOutput("t6_rst_exec_valid", exec_valid_o, 0);
    checkOutput("t6_pre_rst_stall", stall_cnt_o, 6);
    step();
    rst_i = 1'b0;
    #3;
    checkOutput("t6_post_dec_ready", dec_ready_o, 1);
    checkOutput("t6_post_op_a", op_a_o, 0);
    checkOutput("t6_post_op_b", op_b_o, 0);
    checkOutput("t6_post_waddr", waddr_o, 0);
    checkOutput("t6_post_unit", exec_unit_o, 0);
    checkOutput("t6_post_stall", stall_cnt_o, 0);
    checkOutput("t6_post_hazard", hazard_o, 0);
    step();
    // Scoreboard cleared by reset: x9 now reads without stalling
    applyStimulus(1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd16, 3'b010);
    pushExp(32'h99, 32'h0, 3'b010, 5'd16);
    #3;
    checkOutput("t6_x9_hazard", hazard_o, 0);
    checkOutput("t6_x9_rf_re", rf_re_o, 1);
    checkOutput("t6_x9_raddr", rf_raddr_o, 9);
    step(); #3;
    checkOutput("t6_x9_valid", exec_valid_o, 1);
    step(); step();

    checkOutput("all_dispatches_seen", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
